// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: immediate/word widths and the
// extension-select encoding used by the registered path of sign_ext.
package mips_pkg;

    localparam int IMM_W  = 16;
    localparam int WORD_W = 32;

    localparam logic [1:0] EXT_SEXT = 2'b00;
    localparam logic [1:0] EXT_ZEXT = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;
    localparam logic [1:0] EXT_BR   = 2'b11;

endpackage

// File: rtl/sign_ext_core.sv
// Combinational generation of the four immediate-extension views
// (sign, zero, upper-immediate, branch offset) from one raw immediate.
module ext_core
    import mips_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [IN_W-1:0]  imme,
    output logic [OUT_W-1:0] sext,
    output logic [OUT_W-1:0] zext,
    output logic [OUT_W-1:0] lui,
    output logic [OUT_W-1:0] br
);

    localparam int PAD_W = OUT_W - IN_W;

    // Continuous assigns keep X on imme visible on every view.
    assign sext = {{PAD_W{imme[IN_W-1]}}, imme};
    assign zext = {{PAD_W{1'b0}}, imme};
    assign lui  = {imme, {PAD_W{1'b0}}};
    assign br   = {{(PAD_W-2){imme[IN_W-1]}}, imme, 2'b00};

endmodule

// File: rtl/sign_ext.sv
// Immediate-extension unit: combinational extension views plus an optional
// op-selected capture register for pipelined datapaths.
module sign_ext
    import mips_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  imme,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] zext_out,
    output logic [OUT_W-1:0] lui_out,
    output logic [OUT_W-1:0] br_off,
    input  logic [1:0]       ext_op,
    input  logic             load_en,
    output logic [OUT_W-1:0] out_q,
    output logic             out_q_valid
);

    logic [OUT_W-1:0] sel_val;

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext_core (
        .imme (imme),
        .sext (out),
        .zext (zext_out),
        .lui  (lui_out),
        .br   (br_off)
    );

    always_comb begin
        sel_val = out;
        case (ext_op)
            EXT_SEXT: sel_val = out;
            EXT_ZEXT: sel_val = zext_out;
            EXT_LUI:  sel_val = lui_out;
            EXT_BR:   sel_val = br_off;
            default:  sel_val = out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_q_valid <= 1'b0;
        end else if (load_en) begin
            out_q       <= sel_val;
            out_q_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sign_ext.sv
// Self-checking bench for sign_ext: directed literal checks, then randomized
// stimulus compared every cycle against an arithmetic reference model.
module tb_sign_ext;

    logic        clk;
    logic        rst_n;
    logic [15:0] imme;
    logic [31:0] out, zext_out, lui_out, br_off, out_q;
    logic [1:0]  ext_op;
    logic        load_en;
    logic        out_q_valid;

    int tests = 0;
    int fails = 0;
    logic clk_run = 1'b0;
    logic chk_en  = 1'b0;
    logic [31:0] exp_q = '0;
    logic        exp_v = 1'b0;

    sign_ext dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imme        (imme),
        .out         (out),
        .zext_out    (zext_out),
        .lui_out     (lui_out),
        .br_off      (br_off),
        .ext_op      (ext_op),
        .load_en     (load_en),
        .out_q       (out_q),
        .out_q_valid (out_q_valid)
    );

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    // Reference model: plain signed/unsigned arithmetic on the immediate.
    function automatic logic [31:0] m_sext(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        return 32'(s);
    endfunction

    function automatic logic [31:0] m_zext(input logic [15:0] v);
        return 32'(v);
    endfunction

    function automatic logic [31:0] m_lui(input logic [15:0] v);
        return 32'(v) * 32'd65536;
    endfunction

    function automatic logic [31:0] m_br(input logic [15:0] v);
        int s;
        s = int'($signed(v)) * 4;
        return 32'(s);
    endfunction

    function automatic logic [31:0] m_sel(input logic [1:0] op, input logic [15:0] v);
        if (op == 2'd0) return m_sext(v);
        if (op == 2'd1) return m_zext(v);
        if (op == 2'd2) return m_lui(v);
        return m_br(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rnd_out",   out,      m_sext(imme));
            check("rnd_zext",  zext_out, m_zext(imme));
            check("rnd_lui",   lui_out,  m_lui(imme));
            check("rnd_br",    br_off,   m_br(imme));
            check("rnd_q",     out_q,    exp_q);
            check("rnd_valid", 32'(out_q_valid), 32'(exp_v));
        end
    end

    initial begin
        ext_op  = 2'b00;
        load_en = 1'b0;

        // Combinational path with no clock and rst_n untouched.
        imme = 16'hFFFC; #100;
        check("noclk_neg4", out, 32'hFFFFFFFC);
        imme = 16'd155;  #100;
        check("noclk_155", out, 32'h0000009B);

        imme = 16'h8000; #1;
        check("b8000_out",  out,      32'hFFFF8000);
        check("b8000_zext", zext_out, 32'h00008000);
        check("b8000_lui",  lui_out,  32'h80000000);
        check("b8000_br",   br_off,   32'hFFFE0000);
        imme = 16'h7FFF; #1;
        check("b7fff_out", out,    32'h00007FFF);
        check("b7fff_br",  br_off, 32'h0001FFFC);
        imme = 16'h0000; #1;
        check("b0_out",  out,      32'h0);
        check("b0_zext", zext_out, 32'h0);
        check("b0_lui",  lui_out,  32'h0);
        check("b0_br",   br_off,   32'h0);
        imme = 16'hFFFF; #1;
        check("bffff_out", out, 32'hFFFFFFFF);

        // Registered path and reset behaviour.
        rst_n   = 1'b1;
        clk_run = 1'b1;
        imme    = 16'h0005;
        ext_op  = 2'b00;
        load_en = 1'b1;
        @(posedge clk); #1;
        check("pre_load_q", out_q, 32'h00000005);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_q", out_q, 32'h0);
        check("async_rst_v", 32'(out_q_valid), 32'h0);
        @(posedge clk); #1;
        check("rst_over_load_q", out_q, 32'h0);
        check("rst_over_load_v", 32'(out_q_valid), 32'h0);
        rst_n   = 1'b1;
        imme    = 16'h1234;
        ext_op  = 2'b10;
        load_en = 1'b1;
        @(posedge clk); #1;
        check("first_cap_q", out_q, 32'h12340000);
        check("first_cap_v", 32'(out_q_valid), 32'h1);
        load_en = 1'b0;
        imme    = 16'hFFFF;
        @(posedge clk); #1;
        check("hold_q",   out_q, 32'h12340000);
        check("hold_out", out,   32'hFFFFFFFF);
        ext_op  = 2'b01;
        load_en = 1'b1;
        @(posedge clk); #1;
        check("zext_cap_q", out_q, 32'h0000FFFF);

        // Randomized phase; model state tracks the last capture.
        exp_q  = 32'h0000FFFF;
        exp_v  = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (rst_n && load_en) begin
                exp_q = m_sel(ext_op, imme);
                exp_v = 1'b1;
            end
            #1;
            imme    = 16'($urandom);
            ext_op  = 2'($urandom_range(0, 3));
            load_en = ($urandom_range(0, 3) != 0);
            rst_n   = ($urandom_range(0, 24) != 0);
            if (!rst_n) begin
                exp_q = '0;
                exp_v = 1'b0;
            end
        end
        @(posedge clk);
        chk_en = 1'b0;
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
